// File: rtl/instr_mem_pipe_if.sv
// Fetch request/response handshake between the fetch stage (master) and
// the instruction memory (slave).
interface instr_mem_pipe_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_instr;
    logic              resp_fault;

    modport master (
        output req_valid, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_instr, resp_fault
    );

    modport slave (
        input  req_valid, req_addr, resp_ready,
        output req_ready, resp_valid, resp_instr, resp_fault
    );
endinterface

// File: rtl/instr_mem_pipe.sv
// Clocked instruction memory with a LATENCY-deep response pipeline,
// fault flagging, runtime load port, flush and saturating event counters.
module instr_mem_pipe #(
    parameter int unsigned        DATA_W     = 32,
    parameter int unsigned        DEPTH      = 64,
    parameter int unsigned        ADDR_W     = 32,
    parameter int unsigned        LATENCY    = 1,
    parameter logic [DATA_W-1:0]  FAULT_WORD = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    instr_mem_pipe_if.slave   bus,
    input  logic              flush,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic [15:0]       fetch_cnt,
    output logic [15:0]       fault_cnt
);
    localparam int unsigned     IDX_W     = $clog2(DEPTH);
    localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W + 1)'(DEPTH) << 2;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              st_valid [LATENCY];
    logic [DATA_W-1:0] st_instr [LATENCY];
    logic              st_fault [LATENCY];

    logic             advance;
    logic             accept;
    logic             consume;
    logic             req_fault;
    logic             load_ok;
    logic [IDX_W-1:0] req_idx;
    logic [IDX_W-1:0] load_idx;

    always_comb begin
        advance   = !st_valid[LATENCY-1] || bus.resp_ready;
        accept    = bus.req_valid && advance && !flush;
        consume   = st_valid[LATENCY-1] && bus.resp_ready && !flush;
        req_fault = (bus.req_addr[1:0] != 2'b00) || ({1'b0, bus.req_addr} >= MEM_BYTES);
        load_ok   = {1'b0, load_addr} < MEM_BYTES;
        req_idx   = bus.req_addr[IDX_W+1:2];
        load_idx  = load_addr[IDX_W+1:2];
    end

    assign bus.req_ready  = advance && !flush;
    assign bus.resp_valid = st_valid[LATENCY-1];
    assign bus.resp_instr = st_instr[LATENCY-1];
    assign bus.resp_fault = st_fault[LATENCY-1];

    // Contents deliberately survive reset; a same-edge fetch sees the old word.
    always_ff @(posedge clk) begin
        if (load_en && load_ok) begin
            mem[load_idx] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                st_valid[i] <= 1'b0;
                st_instr[i] <= '0;
                st_fault[i] <= 1'b0;
            end
        end else if (flush) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                st_valid[i] <= 1'b0;
            end
        end else if (advance) begin
            st_valid[0] <= accept;
            if (accept) begin
                st_instr[0] <= req_fault ? FAULT_WORD : mem[req_idx];
                st_fault[0] <= req_fault;
            end
            for (int unsigned i = 1; i < LATENCY; i++) begin
                st_valid[i] <= st_valid[i-1];
                st_instr[i] <= st_instr[i-1];
                st_fault[i] <= st_fault[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_cnt <= '0;
            fault_cnt <= '0;
        end else begin
            if (accept && (fetch_cnt != '1)) begin
                fetch_cnt <= fetch_cnt + 16'd1;
            end
            if (consume && st_fault[LATENCY-1] && (fault_cnt != '1)) begin
                fault_cnt <= fault_cnt + 16'd1;
            end
        end
    end
endmodule
